// File: rtl/ysyx_24100012_ctrl_pkg.sv
// Shared control encodings for the exec FSM and the instruction decoder.
package ysyx_24100012_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  // Encodings consumed by the decoder and datapath muxes.
  typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_JAL, PC_JALR} pc_type_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_e;
  typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_RS, CSR_RC} csr_type_e;

  typedef struct packed {
    logic memren;
    logic memwen;
    logic wen;
    logic csrwen;
  } dec_ctl_t;

  function automatic logic is_mem_op(input dec_ctl_t d);
    return d.memren | d.memwen;
  endfunction

endpackage

// File: rtl/ysyx_24100012_exec_ctrl_bus_watchdog.sv
// Bus wait counter: flags a request that has gone LIMIT cycles without a response.
module ysyx_24100012_bus_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic resp,
  output logic expired
);

  localparam int unsigned CW = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [CW-1:0] cnt;

  // Counter is zero on the first wait cycle, so the LIMIT-th silent cycle fires.
  assign expired = waiting && !resp && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !waiting) cnt <= '0;
    else if (!resp)         cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/ysyx_24100012_exec_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with ebreak halt.
// Optional bus watchdog enabled by defining YSYX_24100012_BUS_TIMEOUT_EN.
module ysyx_24100012_exec_ctrl
  import ysyx_24100012_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 64,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_req,
  input  logic                  ifu_rvalid,
  output logic                  inst_we,
  input  logic                  dec_memren,
  input  logic                  dec_memwen,
  input  logic                  dec_wen,
  input  logic                  dec_csrwen,
  input  logic [DATA_WIDTH-1:0] dec_inst,
  output logic                  lsu_req,
  output logic                  lsu_wen,
  input  logic                  lsu_rvalid,
  output logic                  rf_we,
  output logic                  csr_we,
  output logic                  pc_we,
  output logic                  halt,
  output logic                  bus_err,
  output logic [CNT_WIDTH-1:0]  instret,
  output logic [2:0]            state_o
);

  state_e               state;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 bus_err_q;
  logic                 wd_fire;
  dec_ctl_t             dec;

  logic in_fetch, in_mem, in_wb, is_ebreak;

  assign dec       = '{memren: dec_memren, memwen: dec_memwen, wen: dec_wen, csrwen: dec_csrwen};
  assign is_ebreak = (dec_inst == DATA_WIDTH'(EBREAK_INST));

  // Handshakes and commit pulses are qualified by rst_n so nothing leaks while reset is held.
  assign in_fetch = rst_n && (state == S_FETCH);
  assign in_mem   = rst_n && (state == S_MEM);
  assign in_wb    = rst_n && (state == S_WB);

  assign ifu_req = in_fetch;
  assign inst_we = in_fetch && ifu_rvalid;
  assign lsu_req = in_mem;
  assign lsu_wen = in_mem && dec.memwen;
  assign rf_we   = in_wb && dec.wen;
  assign csr_we  = in_wb && dec.csrwen;
  assign pc_we   = in_wb;
  assign halt    = (state == S_HALT);
  assign bus_err = bus_err_q;
  assign instret = instret_q;
  assign state_o = state;

`ifdef YSYX_24100012_BUS_TIMEOUT_EN
  ysyx_24100012_bus_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .waiting((state == S_FETCH) || (state == S_MEM)),
    .resp   (((state == S_FETCH) && ifu_rvalid) || ((state == S_MEM) && lsu_rvalid)),
    .expired(wd_fire)
  );
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      instret_q <= '0;
      bus_err_q <= 1'b0;
    end else if (wd_fire) begin
      state     <= S_HALT;
      bus_err_q <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (ifu_rvalid) state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC:   state <= is_mem_op(dec) ? S_MEM : S_WB;
        S_MEM:    if (lsu_rvalid) state <= S_WB;
        S_WB: begin
          instret_q <= instret_q + CNT_WIDTH'(1);
          state     <= is_ebreak ? S_HALT : S_FETCH;
        end
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_exec_ctrl.sv
// Randomized self-checking bench for the exec control FSM.
module tb_ysyx_24100012_exec_ctrl;

  localparam int DW = 32;
  localparam int CW = 64;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_req, ifu_rvalid, inst_we;
  logic          dec_memren, dec_memwen, dec_wen, dec_csrwen;
  logic [DW-1:0] dec_inst;
  logic          lsu_req, lsu_wen, lsu_rvalid;
  logic          rf_we, csr_we, pc_we, halt, bus_err;
  logic [CW-1:0] instret;
  logic [2:0]    state_o;

  int            vecs = 0;
  int            errs = 0;
  logic [CW-1:0] exp_instret = '0;

  ysyx_24100012_exec_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .inst_we(inst_we),
    .dec_memren(dec_memren), .dec_memwen(dec_memwen), .dec_wen(dec_wen), .dec_csrwen(dec_csrwen),
    .dec_inst(dec_inst), .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_rvalid(lsu_rvalid),
    .rf_we(rf_we), .csr_we(csr_we), .pc_we(pc_we), .halt(halt), .bus_err(bus_err),
    .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; ifu_rvalid = 1'b0; lsu_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_instret = '0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] v;
    v = $urandom();
    if (v == EBREAK) v = v ^ 32'h1;
    return v;
  endfunction

  // kind: 0 alu, 1 load, 2 store, 3 csr, 4 ebreak; fw/mw = silent cycles before each response
  task automatic run_inst(input int kind, input int fw, input int mw);
    int cyc, fcnt, mcnt, lsu_cyc, exp_cyc;
    bit started, done, is_mem, is_st, exp_wen, exp_csr;
    is_st   = (kind == 2);
    is_mem  = (kind == 1) || (kind == 2);
    exp_wen = (kind == 0) || (kind == 1) || (kind == 3);
    exp_csr = (kind == 3);
    dec_memren = (kind == 1); dec_memwen = is_st; dec_wen = exp_wen; dec_csrwen = exp_csr;
    dec_inst = (kind == 4) ? EBREAK : rand_inst();
    exp_cyc = (fw + 1) + 2 + (is_mem ? mw + 1 : 0) + 1;
    cyc = 0; fcnt = 0; mcnt = 0; lsu_cyc = 0; started = 0; done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      ifu_rvalid = ifu_req ? (fcnt == fw) : ($urandom_range(0, 3) == 0);
      lsu_rvalid = lsu_req ? (mcnt == mw) : ($urandom_range(0, 3) == 0);
      #1;
      if (ifu_req) begin started = 1; fcnt++; end
      if (started) cyc++;
      vecs++;
      if (inst_we !== (ifu_req && ifu_rvalid))
        $display("FAIL inst_we: got %b expected %b", inst_we, ifu_req && ifu_rvalid);
      if (inst_we !== (ifu_req && ifu_rvalid)) errs++;
      if (lsu_req) begin
        lsu_cyc++; mcnt++;
        vecs++;
        if (lsu_wen !== is_st) begin errs++; $display("FAIL lsu_wen: got %b expected %b", lsu_wen, is_st); end
      end else if (lsu_wen !== 1'b0) begin
        errs++; $display("FAIL lsu_wen_idle: got %b expected 0", lsu_wen);
      end
      if (bus_err !== 1'b0) begin errs++; $display("FAIL bus_err: got %b expected 0", bus_err); end
      if (pc_we === 1'b1) begin
        done = 1;
        vecs++;
        if (rf_we !== exp_wen || csr_we !== exp_csr) begin
          errs++; $display("FAIL wb_pulses: got rf_we=%b csr_we=%b expected %b %b", rf_we, csr_we, exp_wen, exp_csr);
        end
        vecs++;
        if (cyc !== exp_cyc || lsu_cyc !== (is_mem ? mw + 1 : 0)) begin
          errs++;
          $display("FAIL latency kind=%0d: got %0d/%0d cycles expected %0d/%0d", kind, cyc, lsu_cyc, exp_cyc, is_mem ? mw + 1 : 0);
        end
      end else if (rf_we !== 1'b0 || csr_we !== 1'b0) begin
        errs++; $display("FAIL stray_commit: got rf_we=%b csr_we=%b expected 0 0", rf_we, csr_we);
      end
    end
    if (!done) begin errs++; $display("FAIL wb_timeout kind=%0d: got no pc_we expected one within 100 cycles", kind); end
    exp_instret = exp_instret + 1;
    @(posedge clk); #1;
    vecs++;
    if (instret !== exp_instret) begin errs++; $display("FAIL instret: got %0d expected %0d", instret, exp_instret); end
    vecs++;
    if (halt !== (kind == 4) || state_o !== ((kind == 4) ? 3'd6 : 3'd1)) begin
      errs++; $display("FAIL post_wb kind=%0d: got halt=%b state=%0d expected %b %0d", kind, halt, state_o, kind == 4, (kind == 4) ? 6 : 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifu_rvalid = $urandom_range(0, 1); lsu_rvalid = $urandom_range(0, 1);
      #1;
      vecs++;
      if ({ifu_req, inst_we, lsu_req, lsu_wen, rf_we, csr_we, pc_we, halt, bus_err} !== 9'b0 ||
          state_o !== 3'd0 || instret !== '0) begin
        errs++;
        $display("FAIL reset: got outs=%b state=%0d instret=%0d expected 0 0 0",
                 {ifu_req, inst_we, lsu_req, lsu_wen, rf_we, csr_we, pc_we, halt, bus_err}, state_o, instret);
      end
    end
  endtask

  task automatic test_alu_trace();
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    int n_rf, n_pc;
    do_reset();
    dec_memren = 0; dec_memwen = 0; dec_wen = 1; dec_csrwen = 0; dec_inst = 32'h0000_0013;
    n_rf = 0; n_pc = 0;
    for (int i = 0; i < 8; i++) begin
      ifu_rvalid = (i == 3);
      #1;
      vecs++;
      if (state_o !== exp_st[i]) begin errs++; $display("FAIL alu_trace[%0d]: got %0d expected %0d", i, state_o, exp_st[i]); end
      n_rf += int'(rf_we); n_pc += int'(pc_we);
      @(negedge clk);
    end
    ifu_rvalid = 0;
    vecs++;
    if (n_rf != 1 || n_pc != 1 || instret !== 64'd1) begin
      errs++; $display("FAIL alu_pulses: got rf=%0d pc=%0d instret=%0d expected 1 1 1", n_rf, n_pc, instret);
    end
  endtask

  task automatic test_load_store();
    do_reset();
    run_inst(1, $urandom_range(0, 3), 2);
    run_inst(2, $urandom_range(0, 3), 0);
    run_inst(0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 40; n++) run_inst($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4));
  endtask

  task automatic test_reset_mid_mem();
    bit seen;
    do_reset();
    run_inst(0, 1, 0);
    dec_memren = 1; dec_memwen = 0; dec_wen = 1; dec_csrwen = 0; dec_inst = rand_inst();
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      ifu_rvalid = ifu_req; lsu_rvalid = 0;
      #1;
      seen = lsu_req;
    end
    vecs++;
    if (!seen) begin errs++; $display("FAIL reach_mem: got no lsu_req expected one within 20 cycles"); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; lsu_rvalid = 1;
    #1;
    vecs++;
    if (state_o !== 3'd0 || lsu_req !== 1'b0 || instret !== '0) begin
      errs++; $display("FAIL mid_mem_reset: got state=%0d lsu_req=%b instret=%0d expected 0 0 0", state_o, lsu_req, instret);
    end
    @(negedge clk);
    lsu_rvalid = 0;
    #1;
    vecs++;
    if (state_o !== 3'd1 || pc_we !== 1'b0) begin
      errs++; $display("FAIL late_rvalid: got state=%0d pc_we=%b expected 1 0", state_o, pc_we);
    end
  endtask

  task automatic test_ebreak();
    do_reset();
    run_inst(3, 0, 0);
    run_inst(4, $urandom_range(0, 2), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ifu_rvalid = $urandom_range(0, 1); lsu_rvalid = $urandom_range(0, 1);
      #1;
      vecs++;
      if (ifu_req !== 1'b0 || lsu_req !== 1'b0 || pc_we !== 1'b0 || halt !== 1'b1 || instret !== exp_instret) begin
        errs++;
        $display("FAIL halted[%0d]: got ifu_req=%b lsu_req=%b pc_we=%b halt=%b instret=%0d expected 0 0 0 1 %0d",
                 i, ifu_req, lsu_req, pc_we, halt, instret, exp_instret);
      end
    end
  endtask

`ifdef YSYX_24100012_BUS_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ifu_rvalid = 0; lsu_rvalid = 0;
      #1;
      vecs++;
      if (bus_err !== (k == 9) || halt !== (k == 9)) begin
        errs++; $display("FAIL timeout[%0d]: got bus_err=%b halt=%b expected %b %b", k, bus_err, halt, k == 9, k == 9);
      end
    end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    repeat (300) @(negedge clk);
    #1;
    vecs++;
    if (bus_err !== 1'b0 || state_o !== 3'd1 || ifu_req !== 1'b1) begin
      errs++; $display("FAIL no_watchdog: got bus_err=%b state=%0d ifu_req=%b expected 0 1 1", bus_err, state_o, ifu_req);
    end
  endtask
`endif

  initial begin
    rst_n = 0; ifu_rvalid = 0; lsu_rvalid = 0;
    dec_memren = 0; dec_memwen = 0; dec_wen = 0; dec_csrwen = 0; dec_inst = '0;
    test_reset();
    test_alu_trace();
    test_load_store();
    test_random();
    test_reset_mid_mem();
    test_ebreak();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ysyx_24100012_exec_ctrl.md
Name: ysyx_24100012_exec_ctrl

Overview:
Multi-cycle control FSM that sequences the single-issue datapath around the instruction decoder: fetch → decode → execute → memory → writeback.
- Owns the IFU and LSU request/response handshakes.
- Gates the decoder's write enables into one-cycle commit pulses.
- Counts retired instructions.
- Detects ebreak and halts.

Parameters:
- DATA_WIDTH, 32, instruction and data width.
- CNT_WIDTH, 64, retired-instruction counter width.
- TIMEOUT_CYC, 255, bus watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- ifu_req  output  1  instruction fetch request, held until accepted.
- ifu_rvalid  input  1  fetch response valid; instruction is on the bus this cycle.
- inst_we  output  1  latch fetched instruction into the IR.
- dec_memren  input  1  decoder MemREn.
- dec_memwen  input  1  decoder MemWEn.
- dec_wen  input  1  decoder WEn (GPR write).
- dec_csrwen  input  1  decoder CSRWEn.
- dec_inst  input  DATA_WIDTH  current IR contents.
- lsu_req  output  1  load/store request, held until acknowledged.
- lsu_wen  output  1  store qualifier, valid with lsu_req.
- lsu_rvalid  input  1  load data valid / store acknowledge.
- rf_we  output  1  GPR write commit pulse.
- csr_we  output  1  CSR write commit pulse.
- pc_we  output  1  PC update pulse.
- halt  output  1  sticky; ebreak retired.
- bus_err  output  1  sticky; watchdog fired (optional feature only, else tied 0).
- instret  output  CNT_WIDTH  retired-instruction count.
- state_o  output  3  current state, for debug and the bench.

Behaviour:
- Reset: synchronous; rst_n low on a clk edge forces the following, regardless of state, including mid-fetch or mid-MEM:
  - state = IDLE;
  - all outputs 0;
  - instret = 0.
  Any response arriving during or after reset is ignored.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: one cycle after reset release → FETCH.
- FETCH:
  - ifu_req = 1 every cycle in FETCH.
  - On ifu_rvalid: inst_we = 1 (combinational, same cycle), next state DECODE.
  - Same-cycle response (request and response in one cycle) is legal, giving a minimum FETCH of 1 cycle.
- DECODE: exactly one cycle so decoder outputs settle from the new IR → EXEC.
- EXEC:
  - dec_memren | dec_memwen → MEM.
  - Otherwise → WB.
  - Both enables set at once is treated as a store (lsu_wen = dec_memwen).
- MEM:
  - lsu_req = 1 and lsu_wen = dec_memwen, held every cycle until lsu_rvalid.
  - lsu_rvalid → WB. Same-cycle acknowledge is legal.
- WB: one cycle. All of the following are combinational pulses in WB only:
  - rf_we = dec_wen;
  - csr_we = dec_csrwen;
  - pc_we = 1;
  - instret increments by 1, wrapping modulo 2^CNT_WIDTH.
- WB next state:
  - dec_inst == 32'h00100073 (ebreak) → HALT.
  - Otherwise → FETCH.
- HALT:
  - halt = 1.
  - All request and write outputs are 0.
  - Left only by reset.
- Ignored responses: ifu_rvalid outside FETCH and lsu_rvalid outside MEM are dropped; there is no state change.
- Minimum latency per instruction: non-memory 4 cycles (FETCH, DECODE, EXEC, WB); load/store 5 cycles.

Optional Feature:
- YSYX_24100012_BUS_TIMEOUT_EN defined:
  - A wait counter, 8 bits minimum, clears on entering FETCH or MEM and counts each cycle without a response.
  - On reaching TIMEOUT_CYC: bus_err = 1 (sticky), state → HALT, halt = 1.
- Undefined: no counter; bus_err tied 0; waits are unbounded.

Decomposition:
- Shared package ysyx_24100012_ctrl_pkg:
  - state encodings;
  - EBREAK_INST constant;
  - PCType, WBSel and csrType encodings shared with the decoder.
- One natural sub-module: ysyx_24100012_bus_watchdog, holding the counter and compare logic for the optional feature.

Test Plan:
- Reset release, ifu_rvalid returned 2 cycles after ifu_req, ALU op (dec_wen=1) → state_o 0→1→1→1→2→3→5→1; rf_we and pc_we pulse once; instret = 1.
- Load (dec_memren=1), lsu_rvalid after 3 cycles → lsu_req high 3 cycles with lsu_wen=0; rf_we pulses in WB; instret increments.
- Store (dec_memwen=1, dec_wen=0), same-cycle acknowledge → MEM lasts 1 cycle; lsu_wen=1; rf_we stays 0.
- dec_inst = 32'h00100073 reaching WB → halt = 1 next cycle and stays 1; ifu_req stays 0 for 20 cycles; instret frozen.
- rst_n low while in MEM with lsu_req high → next cycle state_o = 0, lsu_req = 0, instret = 0; a late lsu_rvalid is ignored.
- With YSYX_24100012_BUS_TIMEOUT_EN and TIMEOUT_CYC = 8, ifu_rvalid never asserted → bus_err = 1 and halt = 1 after 8 cycles in FETCH.
